// File: rtl/multdiv_seq.sv
// multdiv_seq: multi-cycle signed multiply/divide sequencer.
// Multiply uses radix-2 Booth; divide is restoring division on magnitudes.
// All arithmetic goes through the external shared 32-bit adder, one use per cycle.
// The result, exception and ready outputs are registered, so the ready pulse
// appears in the cycle after the FSM leaves DONE.
module multdiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] add_A,
  output logic [WIDTH-1:0] add_B,
  output logic             add_c0,
  input  logic [WIDTH-1:0] add_S,
  input  logic             add_ovf,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    M_ITER = 3'd1,
    D_ABSA = 3'd2,
    D_ABSB = 3'd3,
    D_ITER = 3'd4,
    D_FIX  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] hi;       // Booth HI / divide remainder R
  logic [WIDTH-1:0] lo;       // Booth LO / dividend magnitude, then quotient Q
  logic [WIDTH-1:0] m;        // multiplicand M / divisor (then |divisor|)
  logic             qb;       // Booth q(-1) bit
  logic             is_mult;
  logic             neg;      // quotient must be negated
  logic             div_ovf;  // most-negative / -1 case

  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] qs;
  logic             cout;
  logic             sgn;

  assign rs   = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign qs   = {lo[WIDTH-2:0], 1'b0};
  // Unsigned carry-out of the adder, rebuilt from the operand and sum MSBs.
  assign cout = (add_A[WIDTH-1] & add_B[WIDTH-1]) |
                ((add_A[WIDTH-1] | add_B[WIDTH-1]) & ~add_S[WIDTH-1]);
  // True sign of the 33-bit signed sum, valid even when the adder overflows.
  assign sgn  = add_S[WIDTH-1] ^ add_ovf;

  // Shared adder operand selection for the current state.
  always_comb begin
    add_A  = '0;
    add_B  = '0;
    add_c0 = 1'b0;
    case (state)
      M_ITER: begin
        add_A = hi;
        case ({lo[0], qb})
          2'b01: add_B = m;
          2'b10: begin
            add_B  = ~m;
            add_c0 = 1'b1;
          end
          default: ;
        endcase
      end
      D_ABSA: begin
        if (lo[WIDTH-1]) begin
          add_B  = ~lo;
          add_c0 = 1'b1;
        end
      end
      D_ABSB: begin
        if (m[WIDTH-1]) begin
          add_B  = ~m;
          add_c0 = 1'b1;
        end
      end
      D_ITER: begin
        add_A  = rs;
        add_B  = ~m;
        add_c0 = 1'b1;
      end
      D_FIX: begin
        if (neg) begin
          add_B  = ~lo;
          add_c0 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM with datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      hi             <= '0;
      lo             <= '0;
      m              <= '0;
      qb             <= 1'b0;
      is_mult        <= 1'b0;
      neg            <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            data_resultRDY <= 1'b1;
            if (is_mult) begin
              data_result    <= lo;
              data_exception <= (hi != {WIDTH{lo[WIDTH-1]}});
            end else if (m == '0) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else begin
              data_result    <= lo;
              data_exception <= div_ovf;
            end
          end
          if (ctrl_mult) begin
            hi      <= '0;
            lo      <= data_operandB;
            m       <= data_operandA;
            qb      <= 1'b0;
            cnt     <= '0;
            is_mult <= 1'b1;
            busy    <= 1'b1;
            state   <= M_ITER;
          end else if (ctrl_div) begin
            hi      <= '0;
            lo      <= data_operandA;
            m       <= data_operandB;
            cnt     <= '0;
            is_mult <= 1'b0;
            neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_ovf <= (data_operandA == MIN_NEG) && (data_operandB == '1);
            if (data_operandB == '0) begin
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= D_ABSA;
            end
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        M_ITER: begin
          hi  <= {sgn, add_S[WIDTH-1:1]};
          lo  <= {add_S[0], lo[WIDTH-1:1]};
          qb  <= lo[0];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        D_ABSA: begin
          if (lo[WIDTH-1]) lo <= add_S;
          state <= D_ABSB;
        end
        D_ABSB: begin
          if (m[WIDTH-1]) m <= add_S;
          hi    <= '0;
          cnt   <= '0;
          state <= D_ITER;
        end
        D_ITER: begin
          if (cout || rs[WIDTH-1]) begin
            hi <= add_S;
            lo <= qs | {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            hi <= rs;
            lo <= qs;
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= D_FIX;
        end
        D_FIX: begin
          if (neg) lo <= add_S;
          busy  <= 1'b0;
          state <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: directed checks of the multiply/divide sequencer,
// with a behavioural shared adder attached to the adder ports.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_mult = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] add_A;
  logic [31:0] add_B;
  logic        add_c0;
  logic [31:0] add_S;
  logic        add_ovf;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  // Shared 32-bit adder with signed-overflow flag.
  assign add_S   = add_A + add_B + {31'b0, add_c0};
  assign add_ovf = (add_A[31] == add_B[31]) && (add_S[31] != add_A[31]);

  multdiv_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .add_A          (add_A),
    .add_B          (add_B),
    .add_c0         (add_c0),
    .add_S          (add_S),
    .add_ovf        (add_ovf),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // Start an operation and wait (bounded) for the ready pulse.
  // inject_at >= 0 raises ctrl_div for one cycle during iteration inject_at.
  task automatic do_op(input logic m_in, input logic d_in, input logic [31:0] a,
                       input logic [31:0] b, input int inject_at,
                       output int lat, output int busy_cycles,
                       output logic [31:0] res, output logic exc);
    ctrl_mult     = m_in;
    ctrl_div      = d_in;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock); #1;
    ctrl_mult   = 1'b0;
    ctrl_div    = 1'b0;
    lat         = -1;
    res         = '0;
    exc         = 1'b0;
    busy_cycles = busy ? 1 : 0;
    for (int k = 1; k <= 100; k++) begin
      if (k - 1 == inject_at) begin
        ctrl_div      = 1'b1;
        data_operandA = 32'h0000_1234;
        data_operandB = 32'h0000_0003;
      end
      @(posedge clock); #1;
      ctrl_div = 1'b0;
      if (data_resultRDY) begin
        lat = k;
        res = data_result;
        exc = data_exception;
        break;
      end
      if (busy) busy_cycles++;
    end
    $display("op mult=%0b div=%0b a=%h b=%h -> result=%h exc=%0b latency=%0d",
             m_in, d_in, a, b, res, exc, lat);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (data_result !== 32'h0) begin
      miscompares++; $display("FAIL reset_result: got %h expected 00000000", data_result);
    end
    vectors++;
    if (data_exception !== 1'b0) begin
      miscompares++; $display("FAIL reset_exc: got %b expected 0", data_exception);
    end
    vectors++;
    if (data_resultRDY !== 1'b0) begin
      miscompares++; $display("FAIL reset_rdy: got %b expected 0", data_resultRDY);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    vectors++;
    if ({add_A, add_B, add_c0} !== 65'h0) begin
      miscompares++; $display("FAIL reset_adder: got A=%h B=%h c0=%b expected all 0", add_A, add_B, add_c0);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
    $display("reset released");
  endtask

  task automatic test_mult;
    int lat, bc;
    logic [31:0] r;
    logic e;
    do_op(1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, -1, lat, bc, r, e);
    vectors++;
    if (lat !== 33) begin
      miscompares++; $display("FAIL mult_latency: got %0d expected 33", lat);
    end
    vectors++;
    if (bc !== 32) begin
      miscompares++; $display("FAIL mult_busy_cycles: got %0d expected 32", bc);
    end
    vectors++;
    if (r !== 32'hFFFF_FFEB) begin
      miscompares++; $display("FAIL mult_7x-3_result: got %h expected ffffffeb", r);
    end
    vectors++;
    if (e !== 1'b0) begin
      miscompares++; $display("FAIL mult_7x-3_exc: got %b expected 0", e);
    end
    @(posedge clock); #1;
    vectors++;
    if (data_resultRDY !== 1'b0 || data_result !== 32'hFFFF_FFEB) begin
      miscompares++; $display("FAIL rdy_pulse_hold: got rdy=%b result=%h expected rdy=0 result=ffffffeb",
                              data_resultRDY, data_result);
    end
    do_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, -1, lat, bc, r, e);
    vectors++;
    if (r !== 32'h0000_0000) begin
      miscompares++; $display("FAIL mult_2p32_result: got %h expected 00000000", r);
    end
    vectors++;
    if (e !== 1'b1) begin
      miscompares++; $display("FAIL mult_2p32_exc: got %b expected 1", e);
    end
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, -1, lat, bc, r, e);
    vectors++;
    if (r !== 32'h8000_0000) begin
      miscompares++; $display("FAIL mult_minneg_result: got %h expected 80000000", r);
    end
    vectors++;
    if (e !== 1'b0) begin
      miscompares++; $display("FAIL mult_minneg_exc: got %b expected 0", e);
    end
  endtask

  task automatic test_div;
    int lat, bc;
    logic [31:0] r;
    logic e;
    do_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'h0000_0007, -1, lat, bc, r, e);
    vectors++;
    if (lat !== 36) begin
      miscompares++; $display("FAIL div_latency: got %0d expected 36", lat);
    end
    vectors++;
    if (r !== 32'hFFFF_FFF2) begin
      miscompares++; $display("FAIL div_-100/7_result: got %h expected fffffff2", r);
    end
    vectors++;
    if (e !== 1'b0) begin
      miscompares++; $display("FAIL div_-100/7_exc: got %b expected 0", e);
    end
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0002, -1, lat, bc, r, e);
    vectors++;
    if (r !== 32'hC000_0000) begin
      miscompares++; $display("FAIL div_minneg/2_result: got %h expected c0000000", r);
    end
    vectors++;
    if (e !== 1'b0) begin
      miscompares++; $display("FAIL div_minneg/2_exc: got %b expected 0", e);
    end
    do_op(1'b0, 1'b1, 32'h0000_03E8, 32'hFFFF_FFF9, -1, lat, bc, r, e);
    vectors++;
    if (r !== 32'hFFFF_FF72) begin
      miscompares++; $display("FAIL div_1000/-7_result: got %h expected ffffff72", r);
    end
  endtask

  task automatic test_div_special;
    int lat, bc;
    logic [31:0] r;
    logic e;
    do_op(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000, -1, lat, bc, r, e);
    vectors++;
    if (lat !== 1) begin
      miscompares++; $display("FAIL divzero_latency: got %0d expected 1", lat);
    end
    vectors++;
    if (r !== 32'h0) begin
      miscompares++; $display("FAIL divzero_result: got %h expected 00000000", r);
    end
    vectors++;
    if (e !== 1'b1) begin
      miscompares++; $display("FAIL divzero_exc: got %b expected 1", e);
    end
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, bc, r, e);
    vectors++;
    if (e !== 1'b1) begin
      miscompares++; $display("FAIL divovf_exc: got %b expected 1", e);
    end
    vectors++;
    if (r !== 32'h8000_0000) begin
      miscompares++; $display("FAIL divovf_result: got %h expected 80000000", r);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bc;
    logic [31:0] r;
    logic e;
    do_op(1'b1, 1'b0, 32'h0000_0064, 32'hFFFF_FFFB, 10, lat, bc, r, e);
    vectors++;
    if (lat !== 33) begin
      miscompares++; $display("FAIL ignore_latency: got %0d expected 33", lat);
    end
    vectors++;
    if (r !== 32'hFFFF_FE0C) begin
      miscompares++; $display("FAIL ignore_result: got %h expected fffffe0c", r);
    end
    vectors++;
    if (e !== 1'b0) begin
      miscompares++; $display("FAIL ignore_exc: got %b expected 0", e);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [31:0] r;
    logic e;
    do_op(1'b1, 1'b0, 32'h0000_0006, 32'h0000_0007, -1, lat, bc, r, e);
    vectors++;
    if (r !== 32'h0000_002A) begin
      miscompares++; $display("FAIL b2b_first_result: got %h expected 0000002a", r);
    end
    do_op(1'b1, 1'b0, 32'h0000_0003, 32'hFFFF_FFFC, -1, lat, bc, r, e);
    vectors++;
    if (lat !== 33) begin
      miscompares++; $display("FAIL b2b_second_latency: got %0d expected 33", lat);
    end
    vectors++;
    if (r !== 32'hFFFF_FFF4) begin
      miscompares++; $display("FAIL b2b_second_result: got %h expected fffffff4", r);
    end
  endtask

  task automatic test_both_start;
    int lat, bc;
    logic [31:0] r;
    logic e;
    do_op(1'b1, 1'b1, 32'h0000_0009, 32'h0000_0003, -1, lat, bc, r, e);
    vectors++;
    if (r !== 32'h0000_001B) begin
      miscompares++; $display("FAIL both_result: got %h expected 0000001b", r);
    end
    vectors++;
    if (lat !== 33) begin
      miscompares++; $display("FAIL both_latency: got %0d expected 33", lat);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc, seen;
    logic [31:0] r;
    logic e;
    ctrl_div      = 1'b1;
    data_operandA = 32'h0000_03E8;
    data_operandB = 32'h0000_000A;
    @(posedge clock); #1;
    ctrl_div = 1'b0;
    repeat (17) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
      miscompares++; $display("FAIL midreset_ctrl: got busy=%b rdy=%b expected 0 0", busy, data_resultRDY);
    end
    vectors++;
    if (data_result !== 32'h0 || data_exception !== 1'b0) begin
      miscompares++; $display("FAIL midreset_result: got %h exc=%b expected 00000000 0", data_result, data_exception);
    end
    vectors++;
    if ({add_A, add_B, add_c0} !== 65'h0) begin
      miscompares++; $display("FAIL midreset_adder: got A=%h B=%h c0=%b expected all 0", add_A, add_B, add_c0);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++; $display("FAIL midreset_no_rdy: got %0d pulses expected 0", seen);
    end
    $display("reset applied at divide iteration 15");
    do_op(1'b1, 1'b0, 32'h0000_0006, 32'h0000_0007, -1, lat, bc, r, e);
    vectors++;
    if (r !== 32'h0000_002A || e !== 1'b0) begin
      miscompares++; $display("FAIL after_reset_6x7: got %h exc=%b expected 0000002a 0", r, e);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_special;
    test_ignore_start;
    test_back_to_back;
    test_both_start;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Overall time bound in case the design wedges.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
